// File: rtl/dmem_sramlike_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_sramlike_ctrl_pkg
// Shared memory-stage typedefs: byte-enable mask, word type, SRAM-like bus
// transfer size codes, controller state enum, and the byte-enable to bus-size
// helper used by the data-memory controller.
// -----------------------------------------------------------------------------
package dmem_sramlike_ctrl_pkg;

  typedef logic [3:0]  m_wen_t;
  typedef logic [31:0] word_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN,
    DONE
  } dmem_state_t;

  // Loads arrive with an all-zero mask and fall into the word default, which is
  // what a full-word read wants. Unexpected masks also read/write a full word.
  function automatic logic [1:0] wen_to_size(input m_wen_t wen);
    case (wen)
      4'b1111:                            return SZ_WORD;
      4'b0011, 4'b1100:                   return SZ_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return SZ_BYTE;
      default:                            return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sramlike_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_sramlike_ctrl_if
// SRAM-like data bus (req/addr_ok/data_ok handshake).
//   data_req     master -> slave  bus request
//   data_wr      master -> slave  1 = write
//   data_size    master -> slave  0 byte, 1 half, 2 word
//   data_addr    master -> slave  physical byte address
//   data_wdata   master -> slave  write data
//   data_addr_ok slave -> master  address accepted
//   data_data_ok slave -> master  transaction complete / read data valid
//   data_rdata   slave -> master  read data
// -----------------------------------------------------------------------------
interface dmem_sramlike_ctrl_if;
  import dmem_sramlike_ctrl_pkg::*;

  logic       data_req;
  logic       data_wr;
  logic [1:0] data_size;
  word_t      data_addr;
  word_t      data_wdata;
  logic       data_addr_ok;
  logic       data_data_ok;
  word_t      data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/dmem_addr_map.sv
// -----------------------------------------------------------------------------
// dmem_addr_map
// Combinational kseg0/kseg1 -> physical translation. With PHYS_MAP=1 the
// unmapped segments 0x8000_0000-0xBFFF_FFFF fold onto the low 512 MiB; all
// other addresses pass through unchanged. With PHYS_MAP=0 no translation.
//   vaddr_i  in   32  virtual byte address
//   paddr_o  out  32  physical byte address
// -----------------------------------------------------------------------------
module dmem_addr_map
  import dmem_sramlike_ctrl_pkg::*;
#(
  parameter bit PHYS_MAP = 1'b1
) (
  input  word_t vaddr_i,
  output word_t paddr_o
);

  always_comb begin
    paddr_o = vaddr_i;
    if (PHYS_MAP && ((vaddr_i[31:29] == 3'b100) || (vaddr_i[31:29] == 3'b101))) begin
      paddr_o = {3'b000, vaddr_i[28:0]};
    end
  end

endmodule

// File: rtl/dmem_sramlike_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_sramlike_ctrl
// Memory-stage data-bus master. Takes one load/store per instruction, runs it
// on the SRAM-like bus, stalls the pipeline until data_ok, and holds the raw
// read data for the load-extension logic while in DONE.
//   clk, rst       clock, asynchronous active-high reset
//   req_valid_i    memory stage holds an instruction (stable while stalled)
//   req_wen_i      byte enables; non-zero means store
//   req_ren_i      load request (ignored for stores)
//   req_addr_i     virtual byte address
//   req_wdata_i    lane-aligned write data
//   advance_i      memory stage moves to writeback this cycle
//   flush_i        kill the current memory-stage request
//   stall_o        hold pipeline
//   rdata_o        load data, valid in DONE
//   bus            SRAM-like data bus, master side
// -----------------------------------------------------------------------------
module dmem_sramlike_ctrl
  import dmem_sramlike_ctrl_pkg::*;
#(
  parameter bit PHYS_MAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  m_wen_t                req_wen_i,
  input  logic                  req_ren_i,
  input  word_t                 req_addr_i,
  input  word_t                 req_wdata_i,
  input  logic                  advance_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output word_t                 rdata_o,
  dmem_sramlike_ctrl_if.master  bus
);

  dmem_state_t state_q, state_d;
  word_t       addr_q, addr_d;
  word_t       wdata_q, wdata_d;
  word_t       rdata_q, rdata_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;

  word_t       paddr;
  logic        is_store;
  logic        active;
  logic [1:0]  live_size;
  logic        held;

  dmem_addr_map #(.PHYS_MAP(PHYS_MAP)) u_addr_map (
    .vaddr_i (req_addr_i),
    .paddr_o (paddr)
  );

  assign is_store  = |req_wen_i;
  assign active    = req_valid_i & (is_store | req_ren_i) & ~flush_i;
  assign live_size = wen_to_size(req_wen_i);
  // Once the address is accepted the bus sees the latched copy, so a flush or a
  // new instruction cannot disturb a transaction that is still in flight.
  assign held      = (state_q == DATA) || (state_q == DRAIN);

  assign bus.data_wr    = held ? wr_q    : is_store;
  assign bus.data_size  = held ? size_q  : live_size;
  assign bus.data_addr  = held ? addr_q  : paddr;
  assign bus.data_wdata = held ? wdata_q : req_wdata_i;

  // DRAIN also blocks a following instruction until the killed transfer ends.
  assign stall_o = (active && (state_q != DONE)) || ((state_q == DRAIN) && req_valid_i);
  assign rdata_o = rdata_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    size_d       = size_q;
    rdata_d      = rdata_q;
    bus.data_req = 1'b0;

    case (state_q)
      IDLE, ADDR: begin
        bus.data_req = active;
        if (active) begin
          if (bus.data_addr_ok) begin
            addr_d  = paddr;
            wdata_d = req_wdata_i;
            wr_d    = is_store;
            size_d  = live_size;
            if (bus.data_data_ok) begin
              rdata_d = bus.data_rdata;
              state_d = DONE;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = ADDR;
          end
        end else begin
          // Not yet accepted: a flush simply drops the request.
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bus.data_data_ok) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            rdata_d = bus.data_rdata;
            state_d = DONE;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.data_data_ok) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (advance_i || flush_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_sramlike_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_sramlike_ctrl
// Directed bench for dmem_sramlike_ctrl. Inputs change on the falling edge;
// outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_sramlike_ctrl;
  import dmem_sramlike_ctrl_pkg::*;

  logic   clk;
  logic   rst;
  logic   req_valid;
  m_wen_t req_wen;
  logic   req_ren;
  word_t  req_addr;
  word_t  req_wdata;
  logic   advance;
  logic   flush;
  logic   stall;
  word_t  rdata;

  int n_cmp;
  int n_fail;
  int n_txn;
  int t0;
  int stall_cnt;
  logic seen_done;

  dmem_sramlike_ctrl_if bus_if ();

  dmem_sramlike_ctrl #(.PHYS_MAP(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_wen_i   (req_wen),
    .req_ren_i   (req_ren),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .advance_i   (advance),
    .flush_i     (flush),
    .stall_o     (stall),
    .rdata_o     (rdata),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted bus transactions (request and address handshake in one cycle).
  always @(posedge clk) begin
    if (!rst && bus_if.data_req && bus_if.data_addr_ok) n_txn++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_acks(input logic aok, input logic dok, input word_t rd);
    bus_if.data_addr_ok = aok;
    bus_if.data_data_ok = dok;
    bus_if.data_rdata   = rd;
  endtask

  task automatic set_req(input logic v, input m_wen_t wen, input logic ren,
                         input word_t addr, input word_t wd);
    req_valid = v;
    req_wen   = wen;
    req_ren   = ren;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  // Cycle after the final acks: must be DONE (no stall), then advance out.
  task automatic retire(input string tag);
    @(negedge clk);
    set_acks(1'b0, 1'b0, 32'h0);
    #1;
    chk({tag, "_done_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "_done_req"}, {31'b0, bus_if.data_req}, 32'd0);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    set_req(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_txn = 0;
    rst = 1'b1; advance = 1'b0; flush = 1'b0;
    set_req(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    set_acks(1'b0, 1'b0, 32'h0);

    // Reset state
    #7;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_req", {31'b0, bus_if.data_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SW kseg0, same-cycle addr_ok+data_ok: one stall cycle
    @(negedge clk);
    set_req(1'b1, 4'b1111, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF);
    set_acks(1'b1, 1'b1, 32'h0);
    #1;
    chk("sw_req", {31'b0, bus_if.data_req}, 32'd1);
    chk("sw_wr", {31'b0, bus_if.data_wr}, 32'd1);
    chk("sw_size", {30'b0, bus_if.data_size}, 32'd2);
    chk("sw_addr", bus_if.data_addr, 32'h0000_0010);
    chk("sw_wdata", bus_if.data_wdata, 32'hDEAD_BEEF);
    chk("sw_stall", {31'b0, stall}, 32'd1);
    retire("sw");
    chk("sw_txn", n_txn, 32'd1);

    // LW kseg1: addr_ok after 3 waits, data_ok 2 cycles later
    set_req(1'b1, 4'b0000, 1'b1, 32'hA000_0004, 32'h0);
    #1;
    chk("lw_req", {31'b0, bus_if.data_req}, 32'd1);
    chk("lw_wr", {31'b0, bus_if.data_wr}, 32'd0);
    chk("lw_size", {30'b0, bus_if.data_size}, 32'd2);
    chk("lw_addr", bus_if.data_addr, 32'h0000_0004);
    stall_cnt = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      if (i > 0) @(negedge clk);
      set_acks(i == 3, i == 5, (i == 5) ? 32'h1234_5678 : 32'h0);
      #1;
      if (i == 4) begin
        chk("lw_data_req", {31'b0, bus_if.data_req}, 32'd0);
        chk("lw_data_addr", bus_if.data_addr, 32'h0000_0004);
      end
      if (stall) stall_cnt++;
      else seen_done = 1'b1;
    end
    chk("lw_finished", {31'b0, seen_done}, 32'd1);
    chk("lw_stall_cnt", stall_cnt, 32'd6);
    chk("lw_rdata", rdata, 32'h1234_5678);
    set_acks(1'b0, 1'b0, 32'h0);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    set_req(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);

    // SB lane 2: byte size; acked on its second cycle
    set_req(1'b1, 4'b0100, 1'b0, 32'h8000_0002, 32'h00AB_0000);
    #1;
    chk("sb_size", {30'b0, bus_if.data_size}, 32'd0);
    chk("sb_addr", bus_if.data_addr, 32'h0000_0002);
    chk("sb_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    set_acks(1'b1, 1'b1, 32'h0);
    #1;
    chk("sb_addr_state_req", {31'b0, bus_if.data_req}, 32'd1);
    retire("sb");

    // SH upper half
    set_req(1'b1, 4'b1100, 1'b0, 32'h8000_0006, 32'h5A5A_0000);
    set_acks(1'b1, 1'b1, 32'h0);
    #1;
    chk("sh_size", {30'b0, bus_if.data_size}, 32'd1);
    chk("sh_addr", bus_if.data_addr, 32'h0000_0006);
    retire("sh");

    // Flush in ADDR before acceptance; kseg2 address passes through
    set_req(1'b1, 4'b0000, 1'b1, 32'hC000_1000, 32'h0);
    #1;
    chk("fa_addr", bus_if.data_addr, 32'hC000_1000);
    chk("fa_req", {31'b0, bus_if.data_req}, 32'd1);
    t0 = n_txn;
    @(negedge clk);
    flush = 1'b1;
    set_acks(1'b1, 1'b0, 32'h0);
    #1;
    chk("fa_flush_req", {31'b0, bus_if.data_req}, 32'd0);
    chk("fa_flush_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    set_req(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    set_acks(1'b0, 1'b1, 32'h0);
    #1;
    chk("fa_idle_stall", {31'b0, stall}, 32'd0);
    chk("fa_txn", n_txn, t0);
    @(negedge clk);
    set_acks(1'b0, 1'b0, 32'h0);

    // Flush in DATA, new LW waits in DRAIN, old data discarded
    set_req(1'b1, 4'b0000, 1'b1, 32'h8000_0100, 32'h0);
    set_acks(1'b1, 1'b0, 32'h0);
    #1;
    chk("fd_req", {31'b0, bus_if.data_req}, 32'd1);
    @(negedge clk);
    set_acks(1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    #1;
    chk("fd_flush_req", {31'b0, bus_if.data_req}, 32'd0);
    chk("fd_flush_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    set_req(1'b1, 4'b0000, 1'b1, 32'h8000_0200, 32'h0);
    #1;
    chk("fd_drain1_stall", {31'b0, stall}, 32'd1);
    chk("fd_drain1_req", {31'b0, bus_if.data_req}, 32'd0);
    chk("fd_drain1_addr", bus_if.data_addr, 32'h0000_0100);
    @(negedge clk);
    #1;
    chk("fd_drain2_stall", {31'b0, stall}, 32'd1);
    chk("fd_drain2_req", {31'b0, bus_if.data_req}, 32'd0);
    @(negedge clk);
    set_acks(1'b0, 1'b1, 32'hBAD0_BAD0);
    #1;
    chk("fd_drain3_stall", {31'b0, stall}, 32'd1);
    chk("fd_drain3_req", {31'b0, bus_if.data_req}, 32'd0);
    @(negedge clk);
    set_acks(1'b1, 1'b1, 32'hCAFE_F00D);
    #1;
    chk("fd_new_req", {31'b0, bus_if.data_req}, 32'd1);
    chk("fd_new_addr", bus_if.data_addr, 32'h0000_0200);
    chk("fd_new_stall", {31'b0, stall}, 32'd1);
    retire("fd");
    chk("fd_rdata", rdata, 32'hCAFE_F00D);

    // Asynchronous reset while in DATA
    set_req(1'b1, 4'b0000, 1'b1, 32'h8000_0300, 32'h0);
    set_acks(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    set_acks(1'b0, 1'b0, 32'h0);
    #1;
    chk("rd_data_req", {31'b0, bus_if.data_req}, 32'd0);
    chk("rd_data_stall", {31'b0, stall}, 32'd1);
    rst = 1'b1;
    set_req(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rd_stall", {31'b0, stall}, 32'd0);
    chk("rd_rdata", rdata, 32'h0);
    chk("rd_req", {31'b0, bus_if.data_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
